// File: rtl/lcd_text_arbiter.sv
// Text buffer for a 16x2 LCD: round-robin writers, buffer-wide clear and
// rate-limited refresh scheduling toward the LCD driver.
module lcd_text_arbiter #(
  parameter int          N_REQ        = 2,
  parameter int          NUM_CHARS    = 32,
  parameter int          AW           = $clog2(NUM_CHARS),
  parameter int          REFRESH_MIN  = 1600000,
  parameter int          BUSY_TIMEOUT = 2000000,
  parameter logic [7:0]  BLANK_CHAR   = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ-1:0]     req_last_i,
  input  logic [N_REQ*AW-1:0]  req_addr_i,
  input  logic [N_REQ*8-1:0]   req_char_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  input  logic                 drv_busy_i,
  output logic                 drv_start_o,
  input  logic [AW-1:0]        drv_addr_i,
  output logic [7:0]           drv_char_o,
  output logic                 dirty_o,
  output logic                 busy_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW = $clog2(REFRESH_MIN + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [RW-1:0] CNT_SAT  = RW'(REFRESH_MIN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [AW-1:0] CLR_LAST = AW'(NUM_CHARS - 1);

  typedef enum logic [1:0] {A_IDLE, A_LOCK, A_CLEAR} a_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BUSY} r_state_t;

  a_state_t          a_state_q, a_state_d;
  r_state_t          r_state_q, r_state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]     rr_q, rr_d, pick, g_idx;
  logic              clear_pending_q, clear_pending_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic [RW-1:0]     int_cnt_q, int_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              dirty_q, dirty_d;
  logic              set_dirty_arb, set_dirty_to, found, beat_acc;
  logic              wr_en;
  logic [AW-1:0]     wr_addr, g_addr;
  logic [7:0]        wr_data, g_char;
  logic [7:0]        mem [NUM_CHARS];

  assign grant_o     = grant_q;
  assign dirty_o     = dirty_q;
  assign busy_o      = (a_state_q != A_IDLE);
  // Ready is masked while reset is low so an aborted beat is never acknowledged.
  assign req_ready_o = (a_state_q == A_LOCK && reset) ? grant_q : '0;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant_q[i]) g_idx = IW'(i);
  end

  assign g_addr   = req_addr_i[int'(g_idx)*AW +: AW];
  assign g_char   = req_char_i[int'(g_idx)*8 +: 8];
  assign beat_acc = |(req_valid_i & req_ready_o);

  always_comb begin
    a_state_d       = a_state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    clear_pending_d = clear_pending_q;
    clr_addr_d      = clr_addr_q;
    wr_en           = 1'b0;
    wr_addr         = clr_addr_q;
    wr_data         = BLANK_CHAR;
    set_dirty_arb   = 1'b0;
    found           = 1'b0;
    pick            = rr_q;
    case (a_state_q)
      A_IDLE: begin
        if (clear_i || clear_pending_q) begin
          a_state_d  = A_CLEAR;
          clr_addr_d = '0;
        end else if (|req_valid_i) begin
          // Search starts one past the last served requester.
          for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req_valid_i[(int'(rr_q) + i) % N_REQ]) begin
              found = 1'b1;
              pick  = IW'((int'(rr_q) + i) % N_REQ);
            end
          end
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          a_state_d     = A_LOCK;
        end
      end
      A_LOCK: begin
        if (clear_i) clear_pending_d = 1'b1;
        if (beat_acc) begin
          wr_en   = (int'({1'b0, g_addr}) < NUM_CHARS);
          wr_addr = g_addr;
          wr_data = g_char;
          if (req_last_i[g_idx]) begin
            set_dirty_arb = 1'b1;
            rr_d          = g_idx;
            grant_d       = '0;
            a_state_d     = A_IDLE;
          end
        end
      end
      A_CLEAR: begin
        wr_en      = 1'b1;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == CLR_LAST) begin
          set_dirty_arb   = 1'b1;
          clear_pending_d = 1'b0;
          a_state_d       = A_IDLE;
        end
      end
      default: a_state_d = A_IDLE;
    endcase
  end

  always_comb begin
    r_state_d    = r_state_q;
    to_cnt_d     = to_cnt_q;
    set_dirty_to = 1'b0;
    drv_start_o  = 1'b0;
    int_cnt_d    = (int_cnt_q == CNT_SAT) ? int_cnt_q : int_cnt_q + RW'(1);
    case (r_state_q)
      R_IDLE: begin
        if (dirty_q && !drv_busy_i && int_cnt_q == CNT_SAT) begin
          drv_start_o = 1'b1;
          int_cnt_d   = '0;
          to_cnt_d    = '0;
          r_state_d   = R_WAIT;
        end
      end
      R_WAIT: begin
        if (drv_busy_i) begin
          r_state_d = R_BUSY;
        end else if (to_cnt_q == TO_LAST) begin
          r_state_d    = R_IDLE;
          set_dirty_to = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      R_BUSY: if (!drv_busy_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    // A set landing in the same cycle as a start must survive.
    if (set_dirty_arb || set_dirty_to) dirty_d = 1'b1;
    else if (drv_start_o)              dirty_d = 1'b0;
    else                               dirty_d = dirty_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_state_q       <= A_IDLE;
      grant_q         <= '0;
      rr_q            <= IW'(N_REQ - 1);
      clear_pending_q <= 1'b0;
      clr_addr_q      <= '0;
      r_state_q       <= R_IDLE;
      int_cnt_q       <= CNT_SAT;
      to_cnt_q        <= '0;
      dirty_q         <= 1'b0;
    end else begin
      a_state_q       <= a_state_d;
      grant_q         <= grant_d;
      rr_q            <= rr_d;
      clear_pending_q <= clear_pending_d;
      clr_addr_q      <= clr_addr_d;
      r_state_q       <= r_state_d;
      int_cnt_q       <= int_cnt_d;
      to_cnt_q        <= to_cnt_d;
      dirty_q         <= dirty_d;
    end
  end

  // Buffer storage has no reset; contents persist across reset.
  always_ff @(posedge clk) begin
    if (wr_en && reset) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) drv_char_o <= '0;
    else        drv_char_o <= mem[drv_addr_i];
  end

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Self-checking bench for lcd_text_arbiter: vector table, directed corner
// sequences and randomized messages against a message-level model.
`timescale 1ns/1ps
module tb_lcd_text_arbiter;

  localparam int NR = 2;
  localparam int NC = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_i = 1'b0;
  logic v0 = 0, v1 = 0, l0 = 0, l1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [7:0] c0 = '0, c1 = '0;
  logic [NR-1:0] req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*8-1:0] req_char_i;
  logic drv_busy_i, drv_start_o, dirty_o, busy_o;
  logic [AW-1:0] drv_addr_i = '0;
  logic [7:0] drv_char_o;

  assign req_valid_i = {v1, v0};
  assign req_last_i  = {l1, l0};
  assign req_addr_i  = {a1, a0};
  assign req_char_i  = {c1, c0};

  lcd_text_arbiter #(.N_REQ(NR), .NUM_CHARS(NC), .AW(AW), .REFRESH_MIN(100),
                     .BUSY_TIMEOUT(50), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .clear_i(clear_i), .req_valid_i(req_valid_i),
    .req_last_i(req_last_i), .req_addr_i(req_addr_i), .req_char_i(req_char_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .drv_busy_i(drv_busy_i),
    .drv_start_o(drv_start_o), .drv_addr_i(drv_addr_i), .drv_char_o(drv_char_o),
    .dirty_o(dirty_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v; logic l; logic [AW-1:0] a; logic [7:0] c;
    logic [1:0] eg; logic [1:0] er; logic eb; logic ed; logic es;
  } vec_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] c; logic l; } beat_t;

  int total = 0, bad = 0;
  int cyc = 0, viol = 0;
  int start_q[$], grant_log[$];
  logic [1:0] prev_g = '0;
  logic resp_en = 1'b1, gaps_en = 1'b0;
  beat_t bq0[$], bq1[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (drv_start_o) start_q.push_back(cyc);
    if (grant_o != 2'b00 && prev_g == 2'b00) grant_log.push_back(grant_o == 2'b10 ? 1 : 0);
    prev_g <= grant_o;
    if ((req_ready_o & ~grant_o) != 2'b00) viol <= viol + 1;
  end

  // LCD driver stand-in: busy for 20 cycles after each start.
  initial begin
    drv_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (drv_start_o && resp_en) begin
        @(posedge clk); #1 drv_busy_i = 1'b1;
        repeat (20) @(posedge clk);
        #1 drv_busy_i = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_beat(input int k, input logic vv, input logic [AW-1:0] aa,
                          input logic [7:0] cc, input logic ll);
    if (k == 0) begin v0 = vv; a0 = aa; c0 = cc; l0 = ll; end
    else        begin v1 = vv; a1 = aa; c1 = cc; l1 = ll; end
  endtask

  task automatic do_reset();
    repeat (40) @(posedge clk);
    #1 reset = 1'b0; clear_i = 1'b0;
    set_beat(0, 0, '0, '0, 0); set_beat(1, 0, '0, '0, 0);
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic read_char(input logic [AW-1:0] addr, output logic [7:0] ch);
    drv_addr_i = addr;
    @(posedge clk); @(negedge clk);
    ch = drv_char_o;
  endtask

  task automatic drive_req(input int k);
    beat_t b;
    int budget, g;
    while ((k == 0 && bq0.size() > 0) || (k == 1 && bq1.size() > 0)) begin
      if (k == 0) b = bq0.pop_front(); else b = bq1.pop_front();
      set_beat(k, 1, b.a, b.c, b.l);
      budget = 0;
      while (1) begin
        @(negedge clk);
        if (req_ready_o[k]) break;
        budget++;
        if (budget > 3000) break;
      end
      if (budget > 3000) begin
        total++; bad++;
        $display("FAIL req%0d_handshake: ready=0 after 3000 cycles, required 1", k);
        set_beat(k, 0, '0, '0, 0);
        if (k == 0) bq0.delete(); else bq1.delete();
        return;
      end
      @(posedge clk); #1 set_beat(k, 0, '0, '0, 0);
      if (!b.l && gaps_en && $urandom_range(0, 2) == 0) begin
        g = $urandom_range(1, 3);
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 200) begin @(negedge clk); n++; end
    chk(name, busy_o, 0);
  endtask

  task automatic random_test();
    logic [7:0] mbuf [NC];
    int mlen0[$], mlen1[$], order[$], rem[2];
    beat_t mb0[$], mb1[$], b;
    int rr, idx, n, gm, vm;
    logic [7:0] ch;
    do_reset();
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    @(negedge clk);
    wait_idle("rnd_clear_done");
    for (int i = 0; i < NC; i++) mbuf[i] = 8'h20;
    for (int k = 0; k < 2; k++) begin
      rem[k] = $urandom_range(2, 5);
      for (int m = 0; m < rem[k]; m++) begin
        n = $urandom_range(1, 4);
        if (k == 0) mlen0.push_back(n); else mlen1.push_back(n);
        for (int j = 0; j < n; j++) begin
          b.a = AW'($urandom_range(0, NC - 1));
          b.c = 8'($urandom_range(0, 255));
          b.l = (j == n - 1);
          if (k == 0) begin bq0.push_back(b); mb0.push_back(b); end
          else        begin bq1.push_back(b); mb1.push_back(b); end
        end
      end
    end
    // Every requester with pending work keeps valid high, so service order is
    // pure round-robin over "has messages left".
    rr = NR - 1;
    while (rem[0] + rem[1] > 0) begin
      for (int i = 1; i <= NR; i++) begin
        idx = (rr + i) % NR;
        if (rem[idx] > 0) begin
          order.push_back(idx); rem[idx]--; rr = idx;
          break;
        end
      end
    end
    foreach (order[i]) begin
      if (order[i] == 0) begin
        n = mlen0.pop_front();
        repeat (n) begin b = mb0.pop_front(); mbuf[b.a] = b.c; end
      end else begin
        n = mlen1.pop_front();
        repeat (n) begin b = mb1.pop_front(); mbuf[b.a] = b.c; end
      end
    end
    gm = grant_log.size(); vm = viol; gaps_en = 1'b1;
    fork drive_req(0); drive_req(1); join
    gaps_en = 1'b0;
    @(negedge clk);
    chk("rnd_grant_count", grant_log.size() - gm, order.size());
    for (int i = 0; i < order.size() && gm + i < grant_log.size(); i++)
      chk($sformatf("rnd_grant_%0d", i), grant_log[gm + i], order[i]);
    chk("rnd_ready_only_granted", viol - vm, 0);
    for (int i = 0; i < NC; i++) begin
      read_char(AW'(i), ch);
      chk($sformatf("rnd_buf_%0d", i), ch, mbuf[i]);
    end
  endtask

  initial begin
    vec_t tbl[7];
    logic [7:0] ch;
    int m, gm, vm, s, n, mism;

    tbl[0] = '{2'b01, 1'b0, 5'd0, 8'h48, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 5'd0, 8'h48, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{2'b00, 1'b0, 5'd0, 8'h00, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 1'b0, 5'd1, 8'h49, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2'b01, 1'b1, 5'd2, 8'h21, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{2'b00, 1'b0, 5'd0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{2'b00, 1'b0, 5'd0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_start", drv_start_o, 0);
    chk("rst_dirty", dirty_o, 0);
    chk("rst_char", drv_char_o, 0);
    chk("rst_busy", busy_o, 0);

    // Message "HI!" from requester 0 with a gap, cycle by cycle.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_beat(0, tbl[i].v[0], tbl[i].a, tbl[i].c, tbl[i].l);
      set_beat(1, tbl[i].v[1], '0, '0, 0);
      @(negedge clk);
      chk($sformatf("t1_grant_r%0d", i), grant_o, tbl[i].eg);
      chk($sformatf("t1_ready_r%0d", i), req_ready_o, tbl[i].er);
      chk($sformatf("t1_busy_r%0d", i), busy_o, tbl[i].eb);
      chk($sformatf("t1_dirty_r%0d", i), dirty_o, tbl[i].ed);
      chk($sformatf("t1_start_r%0d", i), drv_start_o, tbl[i].es);
    end
    read_char(5'd0, ch); chk("t1_buf0", ch, 8'h48);
    read_char(5'd1, ch); chk("t1_buf1", ch, 8'h49);
    read_char(5'd2, ch); chk("t1_buf2", ch, 8'h21);

    // Both requesters contend with two 2-beat messages each.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      bq0.push_back('{AW'(16 + j), 8'h61 + 8'(j), j[0]});
      bq1.push_back('{AW'(24 + j), 8'h71 + 8'(j), j[0]});
    end
    gm = grant_log.size(); vm = viol;
    fork drive_req(0); drive_req(1); join
    @(negedge clk);
    chk("t2_grant_count", grant_log.size() - gm, 4);
    for (int i = 0; i < 4 && gm + i < grant_log.size(); i++)
      chk($sformatf("t2_grant_%0d", i), grant_log[gm + i], i % 2);
    chk("t2_ready_only_granted", viol - vm, 0);

    // Clear requested mid-message is deferred until the message ends.
    do_reset();
    m = start_q.size();
    for (int j = 0; j < 4; j++) bq1.push_back('{AW'(4 + j), 8'h61 + 8'(j), j == 3});
    fork
      drive_req(1);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (grant_o == 2'b00 && n < 50);
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
      end
    join
    @(negedge clk);
    chk("t3_idle_between", busy_o, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy_o) n++;
      else if (n > 0) break;
    end
    chk("t3_clear_cycles", n, 32);
    repeat (200) @(posedge clk);
    chk("t3_start_count", start_q.size() - m, 2);
    if (start_q.size() - m >= 2) chk("t3_start_gap", start_q[m + 1] - start_q[m], 100);
    mism = 0;
    for (int i = 0; i < NC; i++) begin
      read_char(AW'(i), ch);
      if (ch !== 8'h20) mism++;
    end
    chk("t3_blank_mismatches", mism, 0);

    // Rate limit: second message ends while the driver is still busy.
    do_reset();
    m = start_q.size();
    bq0.push_back('{5'd12, 8'h50, 1'b1});
    drive_req(0);
    repeat (10) @(posedge clk);
    #1 bq0.push_back('{5'd13, 8'h51, 1'b1});
    drive_req(0);
    repeat (250) @(posedge clk);
    chk("t4_start_count", start_q.size() - m, 2);
    if (start_q.size() - m >= 2) chk("t4_start_gap", start_q[m + 1] - start_q[m], 100);
    read_char(5'd13, ch); chk("t4_buf13", ch, 8'h51);

    // Driver never answers: the wait times out and dirty comes back.
    resp_en = 1'b0;
    do_reset();
    m = start_q.size();
    bq0.push_back('{5'd14, 8'h54, 1'b1});
    drive_req(0);
    n = 0;
    while (start_q.size() == m && n < 20) begin @(negedge clk); n++; end
    chk("t5_first_start", start_q.size() - m, 1);
    if (start_q.size() > m) begin
      s = start_q[m];
      while (cyc < s + 50) @(negedge clk);
      chk("t5_dirty_in_wait", dirty_o, 0);
      @(negedge clk);
      chk("t5_dirty_after_timeout", dirty_o, 1);
      while (cyc < s + 120) @(negedge clk);
      chk("t5_start_count", start_q.size() - m, 2);
      if (start_q.size() - m >= 2) chk("t5_restart_gap", start_q[m + 1] - s, 100);
    end
    resp_en = 1'b1;

    // Reset lands on beat 2 of a 4-beat message.
    do_reset();
    @(posedge clk); #1 set_beat(0, 1, 5'd8, 8'h77, 0);
    @(posedge clk);
    @(negedge clk); chk("t6_ready_beat1", req_ready_o, 2'b01);
    @(posedge clk); #1 set_beat(0, 1, 5'd9, 8'h78, 0);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1; set_beat(0, 0, '0, '0, 0);
    @(negedge clk);
    chk("t6_grant", grant_o, 0);
    chk("t6_ready", req_ready_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_dirty", dirty_o, 0);
    chk("t6_start", drv_start_o, 0);
    chk("t6_char", drv_char_o, 0);
    bq0.push_back('{5'd20, 8'h6d, 1'b1});
    bq1.push_back('{5'd21, 8'h6e, 1'b1});
    gm = grant_log.size();
    fork drive_req(0); drive_req(1); join
    @(negedge clk);
    chk("t6_grant_count", grant_log.size() - gm, 2);
    if (grant_log.size() > gm) chk("t6_first_grant", grant_log[gm], 0);
    read_char(5'd8, ch); chk("t6_beat1_kept", ch, 8'h77);
    read_char(5'd9, ch); chk("t6_beat2_dropped", ch, 8'h20);

    random_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
